tile_plot_arbiter: RTL and testbench
====================================

// Module: tile_plot_arbiter
// PURPOSE
//   Shares the single VGA adapter write port between up to NREQ tile drawers (game FSM, maze loader, timer display).
//   Each requester asks for one square tile: grid coordinate plus colour. One winner is chosen round-robin.
//   The block sweeps all TILE x TILE pixels onto vga_x/vga_y/vga_colour/vga_plot, then pulses done to the winner.
//   Sits between the per-feature controllers and the VGA adapter; no requester drives plot directly.
// PARAMETERS
//   NREQ       3  number of requesters (2..8)
//   TILE_LOG2  2  log2 of tile edge in pixels (TILE = 1<<TILE_LOG2)
//   GXW        5  grid x coordinate width
//   GYW        5  grid y coordinate width
//   CW         3  colour width
// PORTS
//   clk         in   1             system clock; single clock domain
//   reset       in   1             synchronous, active-high reset
//   req         in   NREQ          level request per requester
//   req_x       in   NREQ*GXW      grid x; requester i in slice [i*GXW +: GXW]
//   req_y       in   NREQ*GYW      grid y, packed likewise
//   req_colour  in   NREQ*CW       tile colour, packed likewise
//   grant       out  NREQ          one-hot; high while the tile of requester i is being drawn
//   done        out  NREQ          one-cycle pulse to the winner when its tile is complete
//   busy        out  1             high in any state other than IDLE
//   vga_x       out  GXW+TILE_LOG2 pixel x = {tile_x, px}
//   vga_y       out  GYW+TILE_LOG2 pixel y = {tile_y, py}
//   vga_colour  out  CW            latched tile colour
//   vga_plot    out  1             pixel write strobe
// BEHAVIOUR
//   - All outputs registered. On reset: state IDLE; grant, done, busy, vga_plot = 0; vga_x/y/colour = 0; rr pointer = NREQ-1, so req[0] wins first.
//   - FSM: IDLE -> PAINT -> DONE -> IDLE.
//   - IDLE:
//     - If req != 0, pick the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
//     - Latch its x/y/colour. Set grant one-hot and ptr = winner. Clear px and py. Go to PAINT.
//   - PAINT:
//     - vga_plot = 1 every cycle. px is the fastest counter; py advances when px wraps at TILE-1.
//     - Lasts exactly TILE*TILE cycles. After pixel (TILE-1, TILE-1), go to DONE.
//   - DONE: vga_plot = 0; done[winner] = 1 for one cycle; grant held. Next state is IDLE with grant = 0.
//   - Latency:
//     - req first seen high in IDLE at cycle N: first pixel (0,0) plotted at N+1, done at N+1+TILE^2.
//     - Back-to-back tiles: period TILE^2+2 cycles.
//   - Handshake:
//     - The requester holds req and its x/y/colour until done.
//     - req must be low in the cycle after done; otherwise it is re-arbitrated as a new tile.
//     - Inputs are sampled only in IDLE. Changes during PAINT are ignored.
//   - req dropped mid-PAINT: the tile still completes and done still pulses.
//   - Simultaneous requests: strictly round-robin. No requester waits more than NREQ-1 tiles.
//   - reset asserted mid-PAINT/DONE: immediate return to IDLE, no done pulse; the partial tile stays on screen.
//   - Coordinate arithmetic is concatenation only, so no overflow is possible. TILE must be a power of 2.
// STRUCTURE
//   - Shared include game_defs.vh holds:
//     - colour codes: BLACK=0, PLAYER=1, ICE=2, GOAL=3
//     - the arbiter FSM state localparams (IDLE=2'd0, PAINT=2'd1, DONE=2'd2).
//   - One sub-module, rr_arbiter (NREQ): combinational one-hot pick from req and ptr; the pointer register lives in the top.
//   - Pixel counters, latch registers and the FSM live in tile_plot_arbiter.
// TESTING (NREQ=3, TILE_LOG2=2)
//   1. Single request:
//      req=001, x=3, y=2, colour=1 ->
//      grant=001 for 17 cycles; 16 plots at vga_x 12..15, vga_y 8..11, px fastest; done[0] pulse at cycle 17; busy low after.
//   2. Contention:
//      req=111 held, each requester drops req after its done ->
//      grant order 001, 010, 100; 18-cycle spacing between grant rises.
//   3. Fairness:
//      req[0] and req[2] always re-request ->
//      grants alternate 001, 100, 001, 100; requester 1 never granted while its req is low.
//   4. Mid-tile input changes:
//      req_x and req_colour changed, and req dropped, at PAINT cycle 5 ->
//      all 16 pixels use the latched values; done still pulses.
//   5. Reset mid-PAINT:
//      reset at PAINT cycle 7 ->
//      next cycle vga_plot=0, grant=0, no done; a following req=010 is granted first in arbitration order after 001.
//   6. Stale request:
//      req held high one cycle past done, others idle ->
//      the same tile is redrawn (second grant); bench flags it as a requester-protocol error.

Source files
------------

// File: rtl/tile_plot_arbiter_pkg.sv
// Shared definitions for the tile plot arbiter: FSM states and colour codes.
package tile_plot_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam logic [2:0] COLOUR_BLACK  = 3'd0;
    localparam logic [2:0] COLOUR_PLAYER = 3'd1;
    localparam logic [2:0] COLOUR_ICE    = 3'd2;
    localparam logic [2:0] COLOUR_GOAL   = 3'd3;

endpackage

// File: rtl/tile_plot_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   win
);

    logic [PW-1:0] idx;

    // Scan ptr+1, ptr+2, ... and keep the first requester found.
    always_comb begin
        pick = '0;
        win  = '0;
        idx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (pick == '0 && req[idx]) begin
                pick[idx] = 1'b1;
                win       = idx;
            end
        end
    end

endmodule

// File: rtl/tile_plot_arbiter.sv
// Round-robin shared VGA write port: sweeps one TILE x TILE tile per grant, then pulses done.
module tile_plot_arbiter
    import tile_plot_arbiter_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int TILE_LOG2 = 2,
    parameter int GXW       = 5,
    parameter int GYW       = 5,
    parameter int CW        = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*GXW-1:0]       req_x,
    input  logic [NREQ*GYW-1:0]       req_y,
    input  logic [NREQ*CW-1:0]        req_colour,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic [GXW+TILE_LOG2-1:0]  vga_x,
    output logic [GYW+TILE_LOG2-1:0]  vga_y,
    output logic [CW-1:0]             vga_colour,
    output logic                      vga_plot
);

    localparam int PW   = $clog2(NREQ);
    localparam int CNTW = 2 * TILE_LOG2;
    localparam int XW   = GXW + TILE_LOG2;
    localparam int YW   = GYW + TILE_LOG2;

    arb_state_t      state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic [NREQ-1:0] grant_next, done_next;
    logic            busy_next, plot_next;
    logic [XW-1:0]   x_next;
    logic [YW-1:0]   y_next;
    logic [CW-1:0]   colour_next;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   win;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .win  (win)
    );

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops.
    // The tile origin is kept in the upper bits of vga_x/vga_y, so no separate latch is needed.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        cnt_next    = cnt;
        grant_next  = grant;
        done_next   = '0;
        plot_next   = 1'b0;
        x_next      = vga_x;
        y_next      = vga_y;
        colour_next = vga_colour;
        case (state)
            IDLE: begin
                grant_next = '0;
                if (req != '0) begin
                    state_next  = PAINT;
                    ptr_next    = win;
                    grant_next  = pick;
                    cnt_next    = '0;
                    plot_next   = 1'b1;
                    x_next      = {req_x[win*GXW +: GXW], {TILE_LOG2{1'b0}}};
                    y_next      = {req_y[win*GYW +: GYW], {TILE_LOG2{1'b0}}};
                    colour_next = req_colour[win*CW +: CW];
                end
            end
            PAINT: begin
                if (cnt == '1) begin
                    state_next = DONE;
                    done_next  = grant;
                end else begin
                    cnt_next  = cnt + 1'b1;
                    plot_next = 1'b1;
                    x_next    = {vga_x[XW-1:TILE_LOG2], cnt_next[TILE_LOG2-1:0]};
                    y_next    = {vga_y[YW-1:TILE_LOG2], cnt_next[CNTW-1:TILE_LOG2]};
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PW'(NREQ - 1);
            cnt        <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            cnt        <= cnt_next;
            grant      <= grant_next;
            done       <= done_next;
            busy       <= busy_next;
            vga_plot   <= plot_next;
            vga_x      <= x_next;
            vga_y      <= y_next;
            vga_colour <= colour_next;
        end
    end

endmodule

// File: tb/tb_tile_plot_arbiter.sv
// Scoreboard bench for tile_plot_arbiter: a transaction-level model predicts every pixel and done pulse.
module tb_tile_plot_arbiter;

    localparam int NREQ      = 3;
    localparam int TILE_LOG2 = 2;
    localparam int GXW       = 5;
    localparam int GYW       = 5;
    localparam int CW        = 3;
    localparam int TILE      = 1 << TILE_LOG2;
    localparam int NPIX      = TILE * TILE;
    localparam int XW        = GXW + TILE_LOG2;
    localparam int YW        = GYW + TILE_LOG2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*GXW-1:0]  req_x;
    logic [NREQ*GYW-1:0]  req_y;
    logic [NREQ*CW-1:0]   req_colour;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [XW-1:0]        vga_x;
    logic [YW-1:0]        vga_y;
    logic [CW-1:0]        vga_colour;
    logic                 vga_plot;

    tile_plot_arbiter #(
        .NREQ      (NREQ),
        .TILE_LOG2 (TILE_LOG2),
        .GXW       (GXW),
        .GYW       (GYW),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              stamp;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [CW-1:0]   c;
        logic [NREQ-1:0] g;
    } pix_t;

    typedef struct {
        int              stamp;
        logic [NREQ-1:0] d;
    } done_t;

    pix_t  pix_q[$];
    done_t done_q[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    // Reference model state (transaction level).
    int next_arb = 0;
    int arb_e    = -1000;
    int last_win = NREQ - 1;
    int last_done[NREQ];
    int mw, rx, ry;
    pix_t  np;
    done_t nd;

    // Monitor scratch.
    pix_t  mp;
    done_t md;
    bit    exp_busy;

    // Driver state.
    bit [NREQ-1:0] auto_rq;
    bit [NREQ-1:0] stale;
    int            cool[NREQ];
    int            drop_cnt[NREQ];
    int            rand_pct;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Model: at each edge where the port is free, pick the next requester after the
    // previous winner and predict its 16 pixels and the done pulse with cycle stamps.
    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            pix_q.delete();
            done_q.delete();
            next_arb = edge_cnt + 1;
            arb_e    = -1000;
            last_win = NREQ - 1;
        end else if (edge_cnt >= next_arb && req != '0) begin
            mw = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (mw < 0 && req[(last_win + k) % NREQ]) mw = (last_win + k) % NREQ;
            end
            rx = int'(req_x[mw*GXW +: GXW]);
            ry = int'(req_y[mw*GYW +: GYW]);
            for (int j = 0; j < NPIX; j++) begin
                np.stamp = edge_cnt + j;
                np.x     = XW'(rx * TILE + j % TILE);
                np.y     = YW'(ry * TILE + j / TILE);
                np.c     = req_colour[mw*CW +: CW];
                np.g     = NREQ'(1 << mw);
                pix_q.push_back(np);
            end
            nd.stamp = edge_cnt + NPIX;
            nd.d     = NREQ'(1 << mw);
            done_q.push_back(nd);
            if (last_done[mw] == edge_cnt - 2)
                $display("NOTE: requester %0d protocol error: req still high the cycle after done, tile redrawn", mw);
            last_done[mw] = edge_cnt + NPIX;
            last_win      = mw;
            arb_e         = edge_cnt;
            next_arb      = edge_cnt + NPIX + 2;
        end
    end

    // Monitor: compare every plotted pixel and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            exp_busy = (edge_cnt >= arb_e) && (edge_cnt <= arb_e + NPIX);
            chk("busy", 64'(busy), 64'(exp_busy));
            if (!exp_busy) chk("idle_outputs", 64'({grant, done, vga_plot}), 64'(0));

            while (pix_q.size() > 0 && pix_q[0].stamp < edge_cnt) begin
                checks++; failures++;
                $display("FAIL missing_plot: got no plot expected pixel x=%0d y=%0d at edge %0d",
                         pix_q[0].x, pix_q[0].y, pix_q[0].stamp);
                pix_q.delete(0);
            end
            if (vga_plot) begin
                if (pix_q.size() > 0 && pix_q[0].stamp == edge_cnt) begin
                    mp = pix_q[0];
                    pix_q.delete(0);
                    chk("pixel_xy_colour_grant", 64'({vga_x, vga_y, vga_colour, grant}),
                        64'({mp.x, mp.y, mp.c, mp.g}));
                end else begin
                    checks++; failures++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d grant=%b expected no plot (edge %0d)",
                             vga_x, vga_y, grant, edge_cnt);
                end
            end

            while (done_q.size() > 0 && done_q[0].stamp < edge_cnt) begin
                checks++; failures++;
                $display("FAIL missing_done: got none expected done=%b at edge %0d", done_q[0].d, done_q[0].stamp);
                done_q.delete(0);
            end
            if (done != '0) begin
                if (done_q.size() > 0 && done_q[0].stamp == edge_cnt) begin
                    md = done_q[0];
                    done_q.delete(0);
                    chk("done_pulse", 64'(done), 64'(md.d));
                    chk("grant_held_at_done", 64'({grant, vga_plot}), 64'({md.d, 1'b0}));
                end else begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got done=%b expected 0 (edge %0d)", done, edge_cnt);
                end
            end
        end
    end

    task automatic set_tile(input int i, input int x, input int y, input int c);
        req_x[i*GXW +: GXW]     = GXW'(x);
        req_y[i*GYW +: GYW]     = GYW'(y);
        req_colour[i*CW +: CW]  = CW'(c);
    endtask

    task automatic raise(input int i);
        set_tile(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
        req[i] = 1'b1;
    endtask

    // One clock of a protocol-following requester agent, driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (cool[i] > 0) cool[i]--;
            if (done[i]) begin
                if (stale[i]) begin
                    stale[i]    = 1'b0;
                    drop_cnt[i] = 2;
                end else begin
                    req[i]  = 1'b0;
                    cool[i] = 2;
                end
            end else if (drop_cnt[i] > 0) begin
                drop_cnt[i]--;
                if (drop_cnt[i] == 0) begin
                    req[i]  = 1'b0;
                    cool[i] = 1;
                end
            end else if (!req[i] && cool[i] == 0 &&
                         (auto_rq[i] || int'($urandom_range(0, 99)) < rand_pct)) begin
                raise(i);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_colour = '0;
        auto_rq = '0; stale = '0; rand_pct = 0;
        for (int i = 0; i < NREQ; i++) begin
            cool[i] = 0; drop_cnt[i] = 0; last_done[i] = -1000;
        end
        repeat (3) tick();
        @(negedge clk);
        chk("reset_vga_xyc", 64'({vga_x, vga_y, vga_colour}), 64'(0));
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single request: x=3, y=2, colour=1 on requester 0.
        set_tile(0, 3, 2, 1);
        req[0] = 1'b1;
        repeat (24) tick();

        // Contention: all three held, each drops after its done.
        for (int i = 0; i < NREQ; i++) raise(i);
        repeat (3 * (NPIX + 2) + 6) tick();

        // Fairness: requesters 0 and 2 keep re-requesting.
        auto_rq[0] = 1'b1; auto_rq[2] = 1'b1;
        raise(0); raise(2);
        repeat (6 * (NPIX + 2)) tick();
        auto_rq = '0;
        repeat (45) tick();

        // Mid-tile changes: new coordinates/colour and req dropped while painting.
        set_tile(0, 17, 9, 5);
        req[0] = 1'b1;
        repeat (6) tick();
        set_tile(0, 30, 1, 2);
        req[0] = 1'b0;
        repeat (20) tick();

        // Reset mid-PAINT, then arbitration restarts from requester 0.
        raise(1);
        repeat (8) tick();
        reset = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            cool[i] = 0; drop_cnt[i] = 0;
        end
        tick();
        reset = 1'b0;
        raise(1); raise(2);
        repeat (45) tick();

        // Stale request held one cycle past done.
        stale[1] = 1'b1;
        raise(1);
        repeat (45) tick();

        // Random traffic.
        rand_pct = 20;
        repeat (500) tick();
        rand_pct = 0;
        repeat (70) tick();

        chk("scoreboard_drained", 64'(pix_q.size() + done_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
